vga_plot_scheduler: RTL and testbench
=====================================

Name: vga_plot_scheduler

Overview:
- Owns the single pixel-write port (x, y, colour, plot) of the 160x120 VGA adapter inside top_VGA.
- Shares that port between a built-in screen-clear sweeper and two drawing clients, for example the circle drawer and the fill engine.
- Clear always has priority. Between the two clients, arbitration is per-pixel round-robin using a valid/ready handshake.
- All adapter-facing outputs are registered, with 1-cycle latency.

Parameters:
- WIDTH, 160, number of screen columns; valid x range is 0..WIDTH-1.
- HEIGHT, 120, number of screen rows; valid y range is 0..HEIGHT-1.
- XW, 8, x coordinate width.
- YW, 7, y coordinate width.
- CW, 3, colour width (R, G, B).

Ports:
- CLOCK_50  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- clear_req  in  1  level request to sweep the whole screen with clear_colour.
- clear_colour  in  CW  fill colour; sampled on the cycle CLEAR is entered.
- clear_done  out  1  one-cycle pulse when the sweep completes.
- a_valid, a_x, a_y, a_colour  in  1/XW/YW/CW  client A pixel request.
- a_ready  out  1  client A pixel accepted this cycle (combinational).
- b_valid, b_x, b_y, b_colour  in  1/XW/YW/CW  client B pixel request.
- b_ready  out  1  client B pixel accepted this cycle (combinational).
- vga_x, vga_y, vga_colour  out  XW/YW/CW  to the adapter (registered).
- vga_plot  out  1  adapter write enable (registered).
- clip  out  1  one-cycle pulse: an accepted pixel was out of range and dropped.
- busy  out  1  high while in CLEAR.

Behaviour:
- Reset values:
  - state = ARB; last_grant = B, so A wins the first contention.
  - vga_x = 0, vga_y = 0, vga_colour = 0, vga_plot = 0.
  - clear_done = 0, clip = 0, busy = 0.
  - Internal sweep counters = 0.
- States: ARB and CLEAR.
- ARB:
  - If clear_req = 1: a_ready = b_ready = 0, clear_colour is latched, and the next state is CLEAR. Clear wins even if a client is valid in the same cycle.
  - Otherwise, with only one client valid, that client gets ready = 1.
  - With both valid, the client that is not last_grant gets ready = 1; last_grant updates to the winner.
  - With neither valid, no ready is asserted and vga_plot = 0 next cycle.
  - ready is never asserted without the matching valid.
  - Clients must hold valid and data stable until ready.
- Accepted pixel:
  - Next cycle, vga_x/vga_y/vga_colour = the accepted data and vga_plot = 1.
  - Exception: if x >= WIDTH or y >= HEIGHT, the pixel is still accepted (ready = 1), but next cycle vga_plot = 0, clip = 1 and vga_x/vga_y hold their previous values.
- CLEAR:
  - busy = 1; a_ready = b_ready = 0.
  - One pixel per cycle, x inner loop 0..WIDTH-1, y outer loop 0..HEIGHT-1.
  - vga_plot = 1 for all WIDTH*HEIGHT cycles (19200 by default), the first being (0,0) and the last (WIDTH-1, HEIGHT-1), all in the latched colour.
  - On the cycle the last pixel is issued to the outputs, the state returns to ARB.
  - clear_done pulses for one cycle, in the cycle the last pixel appears on vga_*.
  - busy drops on the cycle after the last pixel.
  - clear_req is ignored while in CLEAR.
  - If clear_req is still high on return to ARB, a new sweep starts (back-to-back sweeps are permitted).
  - Counters reset to 0 on entering CLEAR.
  - The x/y counters are XW/YW wide; terminal compares use WIDTH-1 and HEIGHT-1, never natural wrap.
- Reset mid-operation: on the cycle after reset is sampled, every output is at its reset value, the sweep is abandoned, and no clear_done is issued.
- Outputs hold their previous vga_x/vga_y/vga_colour whenever vga_plot = 0.

Test Plan:
- Reset, then idle 5 cycles with no requests -> vga_plot = 0, busy = 0, clip = 0, a_ready = b_ready = 0 every cycle.
- Pulse clear_req for 1 cycle with clear_colour = 3'b000 ->
  - busy rises next cycle.
  - Exactly 19200 consecutive vga_plot = 1 cycles, the first at (0,0) and the last at (159,119).
  - clear_done pulses once, coincident with (159,119); busy falls the next cycle.
- A only valid, with (10,20,3'b101) held for 1 cycle -> a_ready = 1 that cycle; next cycle vga_x = 10, vga_y = 20, vga_colour = 3'b101, vga_plot = 1.
- A and B both valid continuously for 6 cycles -> grants A,B,A,B,A,B; each output pixel matches the granted client's data one cycle later.
- A valid with x = 160, y = 5 -> a_ready = 1; next cycle vga_plot = 0, clip = 1, vga_x unchanged.
- clear_req and a_valid in the same cycle, then reset asserted at sweep pixel 500 ->
  - a_ready = 0 throughout the sweep.
  - After reset, all outputs are zero and the state is ARB, with no clear_done pulse.
  - A pending a_valid is granted on the first cycle after reset deasserts.

Source files
------------

// File: rtl/vga_plot_scheduler.sv
// Arbitrates the VGA adapter's single pixel-write port between a full-screen
// clear sweeper (highest priority) and two round-robin drawing clients.
module vga_plot_scheduler #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int XW     = 8,
  parameter int YW     = 7,
  parameter int CW     = 3
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          clear_req,
  input  logic [CW-1:0] clear_colour,
  output logic          clear_done,
  input  logic          a_valid,
  input  logic [XW-1:0] a_x,
  input  logic [YW-1:0] a_y,
  input  logic [CW-1:0] a_colour,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [XW-1:0] b_x,
  input  logic [YW-1:0] b_y,
  input  logic [CW-1:0] b_colour,
  output logic          b_ready,
  output logic [XW-1:0] vga_x,
  output logic [YW-1:0] vga_y,
  output logic [CW-1:0] vga_colour,
  output logic          vga_plot,
  output logic          clip,
  output logic          busy
);

  typedef enum logic {ARB, CLEAR} state_e;

  state_e        state_q, state_d;
  logic          lastB_q, lastB_d;
  logic [CW-1:0] clrColour_q, clrColour_d;
  logic [XW-1:0] xCnt_q, xCnt_d;
  logic [YW-1:0] yCnt_q, yCnt_d;
  logic [XW-1:0] vgaX_q, vgaX_d;
  logic [YW-1:0] vgaY_q, vgaY_d;
  logic [CW-1:0] vgaColour_q, vgaColour_d;
  logic          vgaPlot_q, vgaPlot_d;
  logic          clip_q, clip_d;
  logic          clearDone_q, clearDone_d;
  logic          busy_q, busy_d;

  logic          grantA, grantB;
  logic [XW-1:0] selX;
  logic [YW-1:0] selY;
  logic [CW-1:0] selColour;
  logic          outOfRange;
  logic          lastX, lastY;

  assign lastX = (xCnt_q == XW'(WIDTH - 1));
  assign lastY = (yCnt_q == YW'(HEIGHT - 1));

  // Ready is withheld during reset so a pending client is first granted
  // on the cycle reset is released.
  always_comb begin
    state_d     = state_q;
    lastB_d     = lastB_q;
    clrColour_d = clrColour_q;
    xCnt_d      = xCnt_q;
    yCnt_d      = yCnt_q;
    vgaX_d      = vgaX_q;
    vgaY_d      = vgaY_q;
    vgaColour_d = vgaColour_q;
    vgaPlot_d   = 1'b0;
    clip_d      = 1'b0;
    clearDone_d = 1'b0;
    grantA      = 1'b0;
    grantB      = 1'b0;
    selX        = a_x;
    selY        = a_y;
    selColour   = a_colour;
    outOfRange  = 1'b0;

    case (state_q)
      ARB: begin
        if (clear_req) begin
          state_d     = CLEAR;
          clrColour_d = clear_colour;
          xCnt_d      = '0;
          yCnt_d      = '0;
        end else if (!reset) begin
          grantA = a_valid && (!b_valid || lastB_q);
          grantB = b_valid && !grantA;
          if (a_valid && b_valid) lastB_d = grantB;
          if (grantB) begin
            selX      = b_x;
            selY      = b_y;
            selColour = b_colour;
          end
          outOfRange = (int'(selX) >= WIDTH) || (int'(selY) >= HEIGHT);
          if (grantA || grantB) begin
            if (outOfRange) begin
              clip_d = 1'b1;
            end else begin
              vgaX_d      = selX;
              vgaY_d      = selY;
              vgaColour_d = selColour;
              vgaPlot_d   = 1'b1;
            end
          end
        end
      end
      CLEAR: begin
        vgaX_d      = xCnt_q;
        vgaY_d      = yCnt_q;
        vgaColour_d = clrColour_q;
        vgaPlot_d   = 1'b1;
        if (lastX) begin
          xCnt_d = '0;
          if (lastY) begin
            yCnt_d      = '0;
            state_d     = ARB;
            clearDone_d = 1'b1;
          end else begin
            yCnt_d = yCnt_q + YW'(1);
          end
        end else begin
          xCnt_d = xCnt_q + XW'(1);
        end
      end
    endcase

    // Busy stays up through the cycle the final sweep pixel is displayed.
    busy_d = (state_q == CLEAR) || (state_d == CLEAR);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= ARB;
      lastB_q     <= 1'b1;
      clrColour_q <= '0;
      xCnt_q      <= '0;
      yCnt_q      <= '0;
      vgaX_q      <= '0;
      vgaY_q      <= '0;
      vgaColour_q <= '0;
      vgaPlot_q   <= 1'b0;
      clip_q      <= 1'b0;
      clearDone_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lastB_q     <= lastB_d;
      clrColour_q <= clrColour_d;
      xCnt_q      <= xCnt_d;
      yCnt_q      <= yCnt_d;
      vgaX_q      <= vgaX_d;
      vgaY_q      <= vgaY_d;
      vgaColour_q <= vgaColour_d;
      vgaPlot_q   <= vgaPlot_d;
      clip_q      <= clip_d;
      clearDone_q <= clearDone_d;
      busy_q      <= busy_d;
    end
  end

  assign a_ready    = grantA;
  assign b_ready    = grantB;
  assign vga_x      = vgaX_q;
  assign vga_y      = vgaY_q;
  assign vga_colour = vgaColour_q;
  assign vga_plot   = vgaPlot_q;
  assign clip       = clip_q;
  assign clear_done = clearDone_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_vga_plot_scheduler.sv
// Directed bench for vga_plot_scheduler: reset, full clear sweep, client
// grants and round-robin, clipping, and reset during a sweep.
module tb_vga_plot_scheduler;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       clear_req;
  logic [2:0] clear_colour;
  logic       clear_done;
  logic       a_valid, b_valid, a_ready, b_ready;
  logic [7:0] a_x, b_x, vga_x;
  logic [6:0] a_y, b_y, vga_y;
  logic [2:0] a_colour, b_colour, vga_colour;
  logic       vga_plot, clip, busy;

  int errors = 0;
  int checks = 0;

  vga_plot_scheduler dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .clear_req(clear_req), .clear_colour(clear_colour), .clear_done(clear_done),
    .a_valid(a_valid), .a_x(a_x), .a_y(a_y), .a_colour(a_colour), .a_ready(a_ready),
    .b_valid(b_valid), .b_x(b_x), .b_y(b_y), .b_colour(b_colour), .b_ready(b_ready),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .clip(clip), .busy(busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic cr, input logic [2:0] cc,
                               input logic av, input logic [7:0] ax, input logic [6:0] ay, input logic [2:0] ac,
                               input logic bv, input logic [7:0] bx, input logic [6:0] by, input logic [2:0] bc);
    clear_req = cr; clear_colour = cc;
    a_valid = av; a_x = ax; a_y = ay; a_colour = ac;
    b_valid = bv; b_x = bx; b_y = by; b_colour = bc;
  endtask

  initial begin
    int plotCount, coordErrs, gaps, doneCount, readyErrs, doneErrs, idleErrs;
    logic [7:0] firstX, doneX, capX;
    logic [6:0] firstY, doneY, capY;
    logic [2:0] capColour;
    logic doneBusy, busyAfter, seenDone, afterCaptured, reached;

    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge CLOCK_50);
    checkOutput("rstPlot", vga_plot, 0);
    checkOutput("rstX", vga_x, 0);
    checkOutput("rstBusy", busy, 0);
    reset = 1'b0;

    idleErrs = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLOCK_50);
      if (vga_plot || busy || clip || a_ready || b_ready) idleErrs++;
    end
    checkOutput("idleQuiet", idleErrs, 0);

    // Full clear sweep in colour 0
    applyStimulus(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLOCK_50);
    applyStimulus(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("clrBusyRise", busy, 1);
    checkOutput("clrNoPlotYet", vga_plot, 0);
    plotCount = 0; coordErrs = 0; gaps = 0; doneCount = 0;
    seenDone = 0; afterCaptured = 0; busyAfter = 1'b1; doneBusy = 1'b0;
    firstX = '1; firstY = '1; doneX = '0; doneY = '0;
    for (int c = 0; c < 19210; c++) begin
      @(negedge CLOCK_50);
      if (seenDone && !afterCaptured) begin
        busyAfter = busy;
        afterCaptured = 1'b1;
      end
      if (vga_plot) begin
        if (plotCount == 0) begin firstX = vga_x; firstY = vga_y; end
        if (int'(vga_x) != plotCount % 160 || int'(vga_y) != plotCount / 160 || vga_colour != 3'b000)
          coordErrs++;
        plotCount++;
      end else if (plotCount > 0 && plotCount < 19200) begin
        gaps++;
      end
      if (clear_done) begin
        doneCount++;
        doneX = vga_x; doneY = vga_y; doneBusy = busy;
        seenDone = 1'b1;
      end
    end
    checkOutput("clrPlotCount", plotCount, 19200);
    checkOutput("clrCoordErrs", coordErrs, 0);
    checkOutput("clrGaps", gaps, 0);
    checkOutput("clrFirstX", firstX, 0);
    checkOutput("clrFirstY", firstY, 0);
    checkOutput("clrDoneCount", doneCount, 1);
    checkOutput("clrDoneX", doneX, 159);
    checkOutput("clrDoneY", doneY, 119);
    checkOutput("clrDoneBusy", doneBusy, 1);
    checkOutput("clrBusyFall", busyAfter, 0);

    // Single client A pixel
    applyStimulus(0, 0, 1, 8'd10, 7'd20, 3'b101, 0, 0, 0, 0);
    #1;
    checkOutput("aOnlyReady", a_ready, 1);
    checkOutput("aOnlyBReady", b_ready, 0);
    @(negedge CLOCK_50);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("aOnlyX", vga_x, 10);
    checkOutput("aOnlyY", vga_y, 20);
    checkOutput("aOnlyColour", vga_colour, 3'b101);
    checkOutput("aOnlyPlot", vga_plot, 1);

    // Contention: both valid for 6 cycles, A wins first
    applyStimulus(0, 0, 1, 8'd30, 7'd40, 3'b001, 1, 8'd50, 7'd60, 3'b010);
    for (int i = 0; i < 6; i++) begin
      #1;
      checkOutput($sformatf("rrAReady%0d", i), a_ready, (i % 2 == 0) ? 1 : 0);
      checkOutput($sformatf("rrBReady%0d", i), b_ready, (i % 2 == 1) ? 1 : 0);
      @(negedge CLOCK_50);
      checkOutput($sformatf("rrX%0d", i), vga_x, (i % 2 == 0) ? 30 : 50);
      checkOutput($sformatf("rrY%0d", i), vga_y, (i % 2 == 0) ? 40 : 60);
      checkOutput($sformatf("rrColour%0d", i), vga_colour, (i % 2 == 0) ? 1 : 2);
      checkOutput($sformatf("rrPlot%0d", i), vga_plot, 1);
    end

    // Out-of-range x from A: accepted but clipped
    applyStimulus(0, 0, 1, 8'd160, 7'd5, 3'b111, 0, 0, 0, 0);
    #1;
    checkOutput("clipXReady", a_ready, 1);
    @(negedge CLOCK_50);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 8'd3, 7'd120, 3'b100);
    checkOutput("clipXPlot", vga_plot, 0);
    checkOutput("clipXPulse", clip, 1);
    checkOutput("clipXHoldX", vga_x, 50);
    checkOutput("clipXHoldColour", vga_colour, 2);
    #1;
    checkOutput("clipYReady", b_ready, 1);
    @(negedge CLOCK_50);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("clipYPulse", clip, 1);
    checkOutput("clipYHoldY", vga_y, 60);
    @(negedge CLOCK_50);
    checkOutput("clipEnds", clip, 0);

    // Clear beats a simultaneous A request, then reset mid-sweep
    applyStimulus(1, 3'b110, 1, 8'd70, 7'd80, 3'b100, 0, 0, 0, 0);
    #1;
    checkOutput("clrWinsReady", a_ready, 0);
    @(negedge CLOCK_50);
    applyStimulus(0, 3'b110, 1, 8'd70, 7'd80, 3'b100, 0, 0, 0, 0);
    checkOutput("sweep2Busy", busy, 1);
    plotCount = 0; readyErrs = 0; doneErrs = 0; reached = 1'b0;
    capX = '0; capY = '0; capColour = '0;
    for (int c = 0; c < 700 && !reached; c++) begin
      @(negedge CLOCK_50);
      if (a_ready) readyErrs++;
      if (clear_done) doneErrs++;
      if (vga_plot) begin
        if (plotCount == 500) begin
          reached = 1'b1;
          capX = vga_x; capY = vga_y; capColour = vga_colour;
        end
        plotCount++;
      end
    end
    checkOutput("sweep2Reached", reached, 1);
    checkOutput("sweep2ReadyLow", readyErrs, 0);
    checkOutput("sweep2NoDone", doneErrs, 0);
    checkOutput("sweep2X500", capX, 20);
    checkOutput("sweep2Y500", capY, 3);
    checkOutput("sweep2Colour", capColour, 3'b110);
    reset = 1'b1;
    @(negedge CLOCK_50);
    checkOutput("midRstX", vga_x, 0);
    checkOutput("midRstY", vga_y, 0);
    checkOutput("midRstColour", vga_colour, 0);
    checkOutput("midRstPlot", vga_plot, 0);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstDone", clear_done, 0);
    checkOutput("midRstClip", clip, 0);
    reset = 1'b0;
    #1;
    checkOutput("postRstReady", a_ready, 1);
    @(negedge CLOCK_50);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("postRstX", vga_x, 70);
    checkOutput("postRstY", vga_y, 80);
    checkOutput("postRstColour", vga_colour, 3'b100);
    checkOutput("postRstPlot", vga_plot, 1);
    checkOutput("postRstBusy", busy, 0);
    idleErrs = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLOCK_50);
      if (vga_plot || clear_done || busy) idleErrs++;
    end
    checkOutput("postRstQuiet", idleErrs, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
